// File: rtl/noc_traffic_gen_if.sv
`default_nettype none
// ------------------------------------------------------------------
// noc_traffic_gen_if: injection/ejection flit handshake bundle
// Rev 1.0
// ------------------------------------------------------------------
interface noc_traffic_gen_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid_out;
  logic                  ready_out;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  valid_in;
  logic                  ready_in;

  modport master (
    output data_out, valid_out, ready_in,
    input  ready_out, data_in, valid_in
  );

  modport slave (
    input  data_out, valid_out, ready_in,
    output ready_out, data_in, valid_in
  );
endinterface
`default_nettype wire

// File: rtl/noc_traffic_gen.sv
`default_nettype none
// ------------------------------------------------------------------
// noc_traffic_gen: packet burst injector plus payload-checking sink
// Rev 1.0
// ------------------------------------------------------------------
module noc_traffic_gen #(
  parameter int DATA_WIDTH = 32,
  parameter int NODE_ID    = 0,
  parameter int DEST_WIDTH = 4,
  parameter int NUM_NODES  = 2,
  parameter int PKT_FLITS  = 6,
  parameter int NUM_PKTS   = 1,
  parameter int GAP        = 0,
  parameter int DEST_MODE  = 0,
  parameter int DEST       = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  noc_traffic_gen_if.master        noc,
  output logic                     busy,
  output logic                     done,
  output logic [31:0]              rx_flits,
  output logic [31:0]              rx_pkts,
  output logic                     rx_err
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_HEAD = 3'd1;
  localparam logic [2:0] ST_BODY = 3'd2;
  localparam logic [2:0] ST_GAP  = 3'd3;
  localparam logic [2:0] ST_FIN  = 3'd4;

  logic [2:0]            r_state;
  logic [15:0]           r_seq;
  logic [15:0]           r_pkt_seq;
  logic [15:0]           r_idx;
  logic [31:0]           r_pkt_cnt;
  logic [31:0]           r_gap_cnt;
  logic [DEST_WIDTH-1:0] w_dest;
  logic [DATA_WIDTH-1:0] w_header;
  logic [DATA_WIDTH-1:0] w_payload;
  logic                  w_tx;
  logic                  w_hdr_xfer;
  logic                  w_last_flit;
  logic                  w_last_pkt;

  assign w_tx        = noc.valid_out && noc.ready_out;
  assign w_hdr_xfer  = w_tx && (r_state == ST_HEAD);
  assign w_last_flit = (r_idx == 16'(PKT_FLITS - 1));
  assign w_last_pkt  = (r_pkt_cnt == 32'(NUM_PKTS - 1));

  generate
    if (DEST_MODE == 0) begin : g_fixed_dest
      assign w_dest = DEST_WIDTH'(DEST);
    end else begin : g_rr_dest
      logic [DEST_WIDTH-1:0] r_rr;

      // Next node in the ring, never addressing ourselves.
      function automatic logic [DEST_WIDTH-1:0] rr_next(input logic [DEST_WIDTH-1:0] d);
        int n;
        n = (int'(d) + 1) % NUM_NODES;
        if (n == NODE_ID) n = (n + 1) % NUM_NODES;
        return DEST_WIDTH'(n);
      endfunction

      always_ff @(posedge clk) begin
        if (rst) begin
          r_rr <= DEST_WIDTH'((NODE_ID + 1) % NUM_NODES);
        end else if (w_hdr_xfer) begin
          r_rr <= rr_next(r_rr);
        end
      end

      assign w_dest = r_rr;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_seq     <= '0;
      r_pkt_seq <= '0;
      r_idx     <= '0;
      r_pkt_cnt <= '0;
      r_gap_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state   <= ST_HEAD;
            r_pkt_cnt <= '0;
          end
        end
        ST_HEAD: begin
          if (w_tx) begin
            r_seq     <= r_seq + 16'd1;
            r_pkt_seq <= r_seq;
            r_idx     <= 16'd1;
            r_state   <= ST_BODY;
          end
        end
        ST_BODY: begin
          if (w_tx) begin
            if (w_last_flit) begin
              if (w_last_pkt) begin
                r_state <= ST_FIN;
              end else begin
                r_pkt_cnt <= r_pkt_cnt + 32'd1;
                r_gap_cnt <= '0;
                r_state   <= (GAP > 0) ? ST_GAP : ST_HEAD;
              end
            end else begin
              r_idx <= r_idx + 16'd1;
            end
          end
        end
        ST_GAP: begin
          if (r_gap_cnt == 32'(GAP - 1)) begin
            r_state <= ST_HEAD;
          end else begin
            r_gap_cnt <= r_gap_cnt + 32'd1;
          end
        end
        ST_FIN:  r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Header carries the sequence number of the packet it opens; payload reuses it.
  always_comb begin
    w_header                               = '0;
    w_header[DEST_WIDTH-1:0]               = w_dest;
    w_header[DEST_WIDTH+7:DEST_WIDTH]      = 8'(NODE_ID);
    w_header[DATA_WIDTH-1:16]              = (DATA_WIDTH-16)'(r_seq);
    w_payload                              = DATA_WIDTH'({r_pkt_seq, r_idx});
  end

  assign noc.data_out  = (r_state == ST_HEAD) ? w_header :
                         (r_state == ST_BODY) ? w_payload : '0;
  assign noc.valid_out = (r_state == ST_HEAD) || (r_state == ST_BODY);
  assign noc.ready_in  = !rst;
  assign busy          = (r_state != ST_IDLE);
  assign done          = (r_state == ST_FIN);

  logic [15:0] r_rx_pos;
  logic [31:0] r_rx_flits;
  logic [31:0] r_rx_pkts;
  logic        r_rx_err;
  logic        w_rx;
  logic        w_unused_rx_hi;

  assign w_rx           = noc.valid_in && noc.ready_in;
  assign w_unused_rx_hi = ^noc.data_in[DATA_WIDTH-1:16];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_pos   <= '0;
      r_rx_flits <= '0;
      r_rx_pkts  <= '0;
      r_rx_err   <= 1'b0;
    end else if (w_rx) begin
      r_rx_flits <= r_rx_flits + 32'd1;
      if ((r_rx_pos != 16'd0) && (noc.data_in[15:0] != r_rx_pos)) begin
        r_rx_err <= 1'b1;
      end
      if (r_rx_pos == 16'(PKT_FLITS - 1)) begin
        r_rx_pos  <= '0;
        r_rx_pkts <= r_rx_pkts + 32'd1;
      end else begin
        r_rx_pos <= r_rx_pos + 16'd1;
      end
    end
  end

  assign rx_flits = r_rx_flits;
  assign rx_pkts  = r_rx_pkts;
  assign rx_err   = r_rx_err;

endmodule
`default_nettype wire

// File: tb/tb_noc_traffic_gen.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_noc_traffic_gen: directed vector bench for noc_traffic_gen
// Rev 1.0
// ------------------------------------------------------------------
module tb_noc_traffic_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start1 = 1'b0;
  logic        start2 = 1'b0;
  logic        rdy1 = 1'b1;
  logic        lb = 1'b0;
  logic [31:0] tb_din = '0;
  logic        tb_vin = 1'b0;

  logic        busy1, done1, rx_err1;
  logic [31:0] rx_flits1, rx_pkts1;
  logic        busy2, done2, rx_err2;
  logic [31:0] rx_flits2, rx_pkts2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  noc_traffic_gen_if #(.DATA_WIDTH(32)) bus1 ();
  noc_traffic_gen_if #(.DATA_WIDTH(32)) bus2 ();

  assign bus1.ready_out = rdy1;
  assign bus1.data_in   = lb ? bus1.data_out  : tb_din;
  assign bus1.valid_in  = lb ? bus1.valid_out : tb_vin;
  assign bus2.ready_out = 1'b1;
  assign bus2.data_in   = '0;
  assign bus2.valid_in  = 1'b0;

  noc_traffic_gen dut1 (
    .clk(clk), .rst(rst), .start(start1), .noc(bus1),
    .busy(busy1), .done(done1), .rx_flits(rx_flits1), .rx_pkts(rx_pkts1), .rx_err(rx_err1)
  );

  noc_traffic_gen #(
    .NUM_NODES(4), .NODE_ID(1), .DEST_MODE(1), .NUM_PKTS(4), .GAP(2)
  ) dut2 (
    .clk(clk), .rst(rst), .start(start2), .noc(bus2),
    .busy(busy2), .done(done2), .rx_flits(rx_flits2), .rx_pkts(rx_pkts2), .rx_err(rx_err2)
  );

  typedef struct {
    logic        start;
    logic        rdy;
    logic        v;
    logic [31:0] d;
    logic        busy;
    logic        done;
  } vec_t;

  vec_t vec [21];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic wait_done1(input int max_cycles);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max_cycles && !seen; i++) begin
      @(negedge clk); #1;
      if (done1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL wait_done actual=timeout required=done_pulse");
    end
  endtask

  task automatic send_rx_pkt(input int bad_pos);
    for (int p = 0; p < 6; p++) begin
      @(negedge clk);
      tb_vin = 1'b1;
      tb_din = (p == 0 || p == bad_pos) ? 32'h0000_0007 : 32'(p);
    end
    @(negedge clk);
    tb_vin = 1'b0;
    tb_din = '0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  rr_dest [4];
    logic [31:0] exp_d;
    int pos, pkt;
    rr_dest[0] = 4'd2; rr_dest[1] = 4'd3; rr_dest[2] = 4'd0; rr_dest[3] = 4'd2;

    // start rdy valid data busy done
    vec[0]  = '{1'b1, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
    vec[1]  = '{1'b0, 1'b1, 1'b1, 32'h0000_0001, 1'b1, 1'b0};
    vec[2]  = '{1'b0, 1'b1, 1'b1, 32'h0000_0001, 1'b1, 1'b0};
    vec[3]  = '{1'b0, 1'b1, 1'b1, 32'h0000_0002, 1'b1, 1'b0};
    vec[4]  = '{1'b0, 1'b1, 1'b1, 32'h0000_0003, 1'b1, 1'b0};
    vec[5]  = '{1'b0, 1'b1, 1'b1, 32'h0000_0004, 1'b1, 1'b0};
    vec[6]  = '{1'b0, 1'b1, 1'b1, 32'h0000_0005, 1'b1, 1'b0};
    vec[7]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
    vec[8]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
    vec[9]  = '{1'b1, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
    vec[10] = '{1'b0, 1'b1, 1'b1, 32'h0001_0001, 1'b1, 1'b0};
    vec[11] = '{1'b0, 1'b1, 1'b1, 32'h0001_0001, 1'b1, 1'b0};
    vec[12] = '{1'b0, 1'b0, 1'b1, 32'h0001_0002, 1'b1, 1'b0};
    vec[13] = '{1'b1, 1'b0, 1'b1, 32'h0001_0002, 1'b1, 1'b0};
    vec[14] = '{1'b0, 1'b0, 1'b1, 32'h0001_0002, 1'b1, 1'b0};
    vec[15] = '{1'b0, 1'b1, 1'b1, 32'h0001_0002, 1'b1, 1'b0};
    vec[16] = '{1'b0, 1'b1, 1'b1, 32'h0001_0003, 1'b1, 1'b0};
    vec[17] = '{1'b0, 1'b1, 1'b1, 32'h0001_0004, 1'b1, 1'b0};
    vec[18] = '{1'b0, 1'b1, 1'b1, 32'h0001_0005, 1'b1, 1'b0};
    vec[19] = '{1'b1, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
    vec[20] = '{1'b0, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_valid", 32'(bus1.valid_out), 32'd0);
    check("rst_data", bus1.data_out, 32'd0);
    check("rst_busy", 32'(busy1), 32'd0);
    check("rst_done", 32'(done1), 32'd0);
    check("rst_ready_in", 32'(bus1.ready_in), 32'd0);
    check("rst_rx_flits", rx_flits1, 32'd0);
    check("rst_rx_err", 32'(rx_err1), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("ready_in_after_rst", 32'(bus1.ready_in), 32'd1);

    // Round-robin destinations with a 2-cycle gap
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int c = 1; c <= 32; c++) begin
      #1;
      pos = (c - 1) % 8;
      pkt = (c - 1) / 8;
      check("rr_valid", 32'(bus2.valid_out), 32'((c <= 30) && (pos < 6)));
      check("rr_busy", 32'(busy2), 32'(c <= 31));
      check("rr_done", 32'(done2), 32'(c == 31));
      if ((c <= 30) && (pos < 6)) begin
        if (pos == 0) exp_d = (32'(pkt) << 16) | 32'h10 | 32'(rr_dest[pkt]);
        else          exp_d = (32'(pkt) << 16) | 32'(pos);
        check("rr_data", bus2.data_out, exp_d);
      end
      @(negedge clk);
    end

    // Single packet, then backpressure packet
    for (int i = 0; i < 21; i++) begin
      start1 = vec[i].start;
      rdy1   = vec[i].rdy;
      #1;
      check("vec_valid", 32'(bus1.valid_out), 32'(vec[i].v));
      check("vec_data", bus1.data_out, vec[i].d);
      check("vec_busy", 32'(busy1), 32'(vec[i].busy));
      check("vec_done", 32'(done1), 32'(vec[i].done));
      @(negedge clk);
    end
    start1 = 1'b0;
    rdy1   = 1'b1;

    // Loopback of 3 packets
    lb = 1'b1;
    for (int p = 0; p < 3; p++) begin
      @(negedge clk);
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      wait_done1(20);
    end
    check("lb_rx_flits", rx_flits1, 32'd18);
    check("lb_rx_pkts", rx_pkts1, 32'd3);
    check("lb_rx_err", 32'(rx_err1), 32'd0);
    @(negedge clk);
    lb = 1'b0;

    // Header low bits are not checked; a bad payload index is sticky
    send_rx_pkt(-1);
    check("hdr_ignored_err", 32'(rx_err1), 32'd0);
    check("hdr_ignored_pkts", rx_pkts1, 32'd4);
    send_rx_pkt(3);
    check("bad_err", 32'(rx_err1), 32'd1);
    check("bad_pkts", rx_pkts1, 32'd5);
    send_rx_pkt(-1);
    check("sticky_err", 32'(rx_err1), 32'd1);
    check("sticky_pkts", rx_pkts1, 32'd6);
    check("sticky_flits", rx_flits1, 32'd36);

    // Reset in the middle of a packet body
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("pre_rst_valid", 32'(bus1.valid_out), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("mid_rst_valid", 32'(bus1.valid_out), 32'd0);
    check("mid_rst_data", bus1.data_out, 32'd0);
    check("mid_rst_busy", 32'(busy1), 32'd0);
    check("mid_rst_ready_in", 32'(bus1.ready_in), 32'd0);
    check("mid_rst_rx_pkts", rx_pkts1, 32'd0);
    check("mid_rst_rx_err", 32'(rx_err1), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("post_rst_busy", 32'(busy1), 32'd0);
    start1 = 1'b1;
    start2 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    start2 = 1'b0;
    #1;
    check("post_rst_hdr", bus1.data_out, 32'h0000_0001);
    check("post_rst_valid", 32'(bus1.valid_out), 32'd1);
    check("post_rst_rr_hdr", bus2.data_out, 32'h0000_0012);
    wait_done1(20);
    repeat (40) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/noc_traffic_gen.md
NOC_TRAFFIC_GEN -- requirements
Module: noc_traffic_gen

Interface
REQ-001 Parameter DATA_WIDTH, default 32, sets flit width; it SHALL be at least 32.
REQ-002 Parameter NODE_ID, default 0, is this node's address.
REQ-003 Parameter DEST_WIDTH, default 4, is the destination field width; it SHALL be at most 8.
REQ-004 Parameter NUM_NODES, default 2, is the node count used for destination rotation; it SHALL be at least 2.
REQ-005 Parameter PKT_FLITS, default 6, is flits per packet including header; it SHALL be at least 2.
REQ-006 Parameter NUM_PKTS, default 1, is packets sent per start.
REQ-007 Parameter GAP, default 0, is idle cycles between packets.
REQ-008 Parameter DEST_MODE, default 0, selects destination: 0 = fixed DEST, 1 = round-robin.
REQ-009 Parameter DEST, default 1, is the fixed destination.
REQ-010 clk  input  1  system clock; all logic on posedge; one clock, reset is synchronous and active-high.
REQ-011 rst  input  1  synchronous active-high reset.
REQ-012 start  input  1  one-cycle pulse beginning a packet burst.
REQ-013 data_out  output  DATA_WIDTH  flit to NoC injection port.
REQ-014 valid_out  output  1  data_out holds a valid flit.
REQ-015 ready_out  input  1  NoC accepts the flit this cycle.
REQ-016 data_in  input  DATA_WIDTH  flit from NoC ejection port.
REQ-017 valid_in  input  1  data_in holds a valid flit.
REQ-018 ready_in  output  1  sink accepts the flit; tied to 1 when not in reset.
REQ-019 busy  output  1  burst in progress.
REQ-020 done  output  1  one-cycle pulse after the last flit of the last packet transfers.
REQ-021 rx_flits  output  32  count of received flits.
REQ-022 rx_pkts  output  32  count of received packets.
REQ-023 rx_err  output  1  sticky flag for a payload index mismatch.

Function
REQ-024 A flit SHALL transfer on any posedge where valid_out and ready_out are both 1.
REQ-025 Once valid_out is asserted, valid_out and data_out SHALL stay stable until the flit transfers.
REQ-026 The FSM SHALL have states IDLE, HEAD, BODY, GAP and FIN.
REQ-027 The FSM SHALL transition as follows:
- IDLE to HEAD on start.
- HEAD to BODY on header transfer.
- BODY to GAP (GAP>0) or HEAD (GAP=0) on last-flit transfer when packets remain.
- GAP to HEAD after exactly GAP cycles.
- Last flit of the last packet to FIN.
- FIN to IDLE after one cycle, with done=1 during FIN.
REQ-028 valid_out SHALL be 1 only in HEAD and BODY, so the first header is presented one cycle after start.
REQ-029 busy SHALL be 1 in every state except IDLE.
REQ-030 start SHALL be ignored while busy.
REQ-031 The header flit SHALL be formatted as:
- [DEST_WIDTH-1:0] = destination.
- [DEST_WIDTH+7:DEST_WIDTH] = NODE_ID[7:0].
- [DATA_WIDTH-1:16] = packet sequence number, zero-extended.
- All other bits 0.
REQ-032 Payload flit k (k = 1..PKT_FLITS-1) SHALL be {sequence[15:0], k[15:0]}, zero-extended to DATA_WIDTH.
REQ-033 The sequence number SHALL start at 0 on reset, increment on each header transfer, wrap modulo 2^16, and persist across bursts.
REQ-034 With DEST_MODE=0, the destination SHALL always be DEST.
REQ-035 With DEST_MODE=1, the first destination after reset SHALL be (NODE_ID+1) mod NUM_NODES, advancing by 1 mod NUM_NODES per packet and skipping NODE_ID.
REQ-036 Sink receive behaviour:
- rx_flits SHALL increment on every valid_in&&ready_in cycle.
- The sink SHALL track its flit position mod PKT_FLITS.
- rx_pkts SHALL increment when position PKT_FLITS-1 is received.
REQ-037 When a payload flit at position p≠0 has data_in[15:0]≠p, rx_err SHALL be set and held until reset.
REQ-038 Both counters SHALL wrap modulo 2^32.
REQ-039 The transmit and receive sides SHALL operate independently, including when a transfer happens on both in the same cycle.

Reset
REQ-040 While rst=1, the FSM SHALL be in IDLE and the following SHALL be 0: valid_out, data_out, busy, done, rx_flits, rx_pkts, rx_err, sink position, sequence number, and ready_in.
REQ-041 An rst asserted mid-packet SHALL abort the packet on the next posedge with no further flits; the partial packet SHALL NOT be counted.
REQ-042 The destination rotation SHALL restart from its initial value after reset.

Verification
REQ-043 Scenario "single packet": defaults, start, ready_out=1 -> 0x00000001, 0x00000001..0x00000005 on consecutive cycles; done one cycle after the last flit.
REQ-044 Scenario "backpressure": ready_out=0 for 3 cycles during flit 2 -> data_out holds 0x00000002 and valid_out=1 throughout; the sequence then completes.
REQ-045 Scenario "round-robin gap": NUM_NODES=4, NODE_ID=1, DEST_MODE=1, NUM_PKTS=4, GAP=2 -> header destinations 2,3,0,2; exactly 2 idle cycles between packets; headers carry sequence numbers 0..3.
REQ-046 Scenario "loopback": data_out wired to data_in, 3 packets -> rx_flits=18, rx_pkts=3, rx_err=0.
REQ-047 Scenario "corrupted payload": feed a flit with [15:0]=0x0007 at position 3 -> rx_err=1, remaining set after later good packets.
REQ-048 Scenario "reset mid-burst": rst asserted during BODY -> valid_out=0 next cycle; after rst is released, start produces a header with sequence 0.
